ham74_dec: RTL

- Streaming Hamming(7,4) decoder and single-error corrector; the receive-side counterpart of the Ham encoder.
- Accepts one 7-bit codeword per cycle over a valid/ready handshake.
- Computes the 3-bit syndrome, corrects any single-bit error and emits the 4-bit data word through a 2-stage backpressure-capable pipeline.
- Keeps saturating word and corrected-error counters for link-quality monitoring.

---
 rtl/ham74_pkg.sv | 72 +++++++
 rtl/ham74_sat_cnt.sv | 38 +++
 rtl/ham74_dec.sv | 110 +++++++++++
 3 files changed

// File: rtl/ham74_pkg.sv
// Shared Hamming(7,4) definitions: codeword layout, syndrome, correction and
// the encode helper, used by both the encoder and the decoder.
package ham74_pkg;

    localparam int CW_W  = 7;
    localparam int D_W   = 4;
    localparam int SYN_W = 3;

    // Bit index of each Hamming position (index i is position i+1)
    localparam int P1 = 0;
    localparam int P2 = 1;
    localparam int D0 = 2;
    localparam int P4 = 3;
    localparam int D1 = 4;
    localparam int D2 = 5;
    localparam int D3 = 6;

    // One decoded word as it leaves the corrector
    typedef struct packed {
        logic [D_W-1:0]   data;
        logic [SYN_W-1:0] syn;
        logic             corr;
    } ham74_res_t;

    // Syndrome {s4,s2,s1}: the erroneous position number, or 0 when clean
    function automatic logic [SYN_W-1:0] ham74_syn(input logic [CW_W-1:0] cw);
        logic s1, s2, s4;
        s1 = cw[P1] ^ cw[D0] ^ cw[D1] ^ cw[D3];
        s2 = cw[P2] ^ cw[D0] ^ cw[D2] ^ cw[D3];
        s4 = cw[P4] ^ cw[D1] ^ cw[D2] ^ cw[D3];
        return {s4, s2, s1};
    endfunction

    // Flip the single bit named by a nonzero syndrome
    function automatic logic [CW_W-1:0] ham74_fix(input logic [CW_W-1:0]  cw,
                                                  input logic [SYN_W-1:0] syn);
        logic [CW_W-1:0] flip;
        for (int i = 0; i < CW_W; i++) begin
            flip[i] = (syn == SYN_W'(i + 1));
        end
        return cw ^ flip;
    endfunction

    // Pull the data nibble d[3:0] out of a codeword
    function automatic logic [D_W-1:0] ham74_data(input logic [CW_W-1:0] cw);
        return {cw[D3], cw[D2], cw[D1], cw[D0]};
    endfunction

    // Full decode of a codeword whose syndrome is already known
    function automatic ham74_res_t ham74_decode(input logic [CW_W-1:0]  cw,
                                                input logic [SYN_W-1:0] syn);
        ham74_res_t res;
        res.data = ham74_data(ham74_fix(cw, syn));
        res.syn  = syn;
        res.corr = |syn;
        return res;
    endfunction

    // Encoder side: place data and the three parity bits
    function automatic logic [CW_W-1:0] ham74_enc(input logic [D_W-1:0] d);
        logic [CW_W-1:0] cw;
        cw[D0] = d[0];
        cw[D1] = d[1];
        cw[D2] = d[2];
        cw[D3] = d[3];
        cw[P1] = d[0] ^ d[1] ^ d[3];
        cw[P2] = d[0] ^ d[2] ^ d[3];
        cw[P4] = d[1] ^ d[2] ^ d[3];
        return cw;
    endfunction

endpackage

// File: rtl/ham74_sat_cnt.sv
// Saturating event counter with synchronous clear; clear beats increment.
module ham74_sat_cnt
    import ham74_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear first, otherwise step unless already at all-ones
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/ham74_dec.sv
// Streaming Hamming(7,4) decoder: syndrome in stage A, correction in stage B,
// valid/ready flow control on both sides, saturating link-quality counters.
module ham74_dec
    import ham74_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CW_W-1:0]  in_cw,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [D_W-1:0]   out_data,
    output logic [SYN_W-1:0] out_syn,
    output logic             out_corr,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] word_cnt,
    output logic [CNT_W-1:0] corr_cnt
);

    logic             aValid_q,   aValid_d;
    logic [CW_W-1:0]  aCw_q,      aCw_d;
    logic [SYN_W-1:0] aSyn_q,     aSyn_d;
    logic             outValid_q, outValid_d;
    logic [D_W-1:0]   outData_q,  outData_d;
    logic [SYN_W-1:0] outSyn_q,   outSyn_d;
    logic             outCorr_q,  outCorr_d;

    logic       advB;
    logic       enA;
    logic       outHs;
    ham74_res_t aRes;

    // Pipeline advance: B moves when empty or drained, A moves when B makes room
    always_comb begin
        advB  = !outValid_q || out_ready;
        enA   = !aValid_q || advB;
        outHs = outValid_q && out_ready;
        aRes  = ham74_decode(aCw_q, aSyn_q);
    end

    // Next-state for both stages; each stage holds unless allowed to advance
    always_comb begin
        aValid_d   = aValid_q;
        aCw_d      = aCw_q;
        aSyn_d     = aSyn_q;
        outValid_d = outValid_q;
        outData_d  = outData_q;
        outSyn_d   = outSyn_q;
        outCorr_d  = outCorr_q;
        if (enA) begin
            aValid_d = in_valid;
            aCw_d    = in_cw;
            aSyn_d   = ham74_syn(in_cw);
        end
        if (advB) begin
            outValid_d = aValid_q;
            outData_d  = aRes.data;
            outSyn_d   = aRes.syn;
            outCorr_d  = aRes.corr;
        end
    end

    // Pipeline registers; reset discards anything in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aValid_q   <= 1'b0;
            aCw_q      <= '0;
            aSyn_q     <= '0;
            outValid_q <= 1'b0;
            outData_q  <= '0;
            outSyn_q   <= '0;
            outCorr_q  <= 1'b0;
        end else begin
            aValid_q   <= aValid_d;
            aCw_q      <= aCw_d;
            aSyn_q     <= aSyn_d;
            outValid_q <= outValid_d;
            outData_q  <= outData_d;
            outSyn_q   <= outSyn_d;
            outCorr_q  <= outCorr_d;
        end
    end

    assign in_ready  = enA;
    assign out_valid = outValid_q;
    assign out_data  = outData_q;
    assign out_syn   = outSyn_q;
    assign out_corr  = outCorr_q;

    // Delivered words; the handshake gate keeps idle-cycle X away from counts
    ham74_sat_cnt #(.CNT_W(CNT_W)) uWordCnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (outHs),
        .clr_i (cnt_clr),
        .cnt_o (word_cnt)
    );

    ham74_sat_cnt #(.CNT_W(CNT_W)) uCorrCnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (outHs && outCorr_q),
        .clr_i (cnt_clr),
        .cnt_o (corr_cnt)
    );

endmodule
